// File: rtl/remote_cmd_decoder.sv
// UART (8N1, LSB first) receiver that decodes single-byte ASCII remote commands
// into the car control bus, with a failsafe watchdog that stops the car on link silence.
module remote_cmd_decoder #(
    parameter int unsigned CLK_FREQ       = 100_000_000,
    parameter int unsigned BAUD           = 9600,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [3:0] car_mode,
    output logic [1:0] car_state,
    output logic       shutdown,
    output logic       headlight,
    output logic       yellow_flash,
    output logic       frame_err,
    output logic       cmd_err
);
    localparam int unsigned DIV_RAW = CLK_FREQ / BAUD;
    localparam int unsigned DIV     = (DIV_RAW < 4) ? 4 : DIV_RAW;
    localparam int          CW      = $clog2(DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [31:0]   WD_LAST   = 32'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CMD_F = 8'h46;
    localparam logic [7:0] CMD_B = 8'h42;
    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_C = 8'h43;
    localparam logic [7:0] CMD_S = 8'h53;
    localparam logic [7:0] CMD_P = 8'h50;
    localparam logic [7:0] CMD_H = 8'h48;
    localparam logic [7:0] CMD_Y = 8'h59;
    localparam logic [7:0] CMD_D = 8'h44;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;

    rx_state_t      state;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     rx_byte;
    logic           byte_valid;
    logic           armed;
    logic           rx_meta;
    logic           rxs;
    logic [31:0]    wd_cnt;
    logic           dance;
    logic           is_drive;
    logic           wd_fire;

    // Synchroniser resets low so a line held low across reset release is not mistaken for idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b0;
            rxs     <= 1'b0;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // byte_valid is a one-cycle strobe; rx_byte is stable while it is high and
    // is consumed by the decoder on that same edge (no back-pressure exists).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            armed      <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rxs) armed <= 1'b1;
                    else if (armed) state <= START;
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        rx_byte <= {rxs, rx_byte[7:1]};
                        if (bit_idx == 3'd7) state <= STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            byte_valid <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: if (rxs) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    assign dance = (car_state == 2'b11);

    always_comb begin
        is_drive = byte_valid && (rx_byte inside {CMD_F, CMD_B, CMD_L, CMD_R, CMD_C, CMD_S});
        wd_fire  = (TIMEOUT_CYCLES != 0) && (car_mode != 4'b0000) && (wd_cnt == WD_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            car_mode     <= 4'b0000;
            car_state    <= 2'b00;
            shutdown     <= 1'b0;
            headlight    <= 1'b0;
            yellow_flash <= 1'b0;
            cmd_err      <= 1'b0;
            wd_cnt       <= '0;
        end else begin
            shutdown     <= 1'b0;
            headlight    <= 1'b0;
            yellow_flash <= 1'b0;
            cmd_err      <= 1'b0;
            if (is_drive || car_mode == 4'b0000) wd_cnt <= '0;
            else if (wd_cnt != '1) wd_cnt <= wd_cnt + 32'd1;
            // A drive command on the firing cycle takes precedence over the timeout.
            if (wd_fire && !is_drive) car_mode <= 4'b0000;
            if (byte_valid) begin
                case (rx_byte)
                    CMD_F: if (!dance) car_mode[3:2] <= 2'b10;
                    CMD_B: if (!dance) car_mode[3:2] <= 2'b01;
                    CMD_L: if (!dance) car_mode[1:0] <= 2'b10;
                    CMD_R: if (!dance) car_mode[1:0] <= 2'b01;
                    CMD_C: if (!dance) car_mode[1:0] <= 2'b00;
                    CMD_S: car_mode <= 4'b0000;
                    CMD_P: shutdown <= 1'b1;
                    CMD_H: headlight <= 1'b1;
                    CMD_Y: yellow_flash <= 1'b1;
                    CMD_D: begin
                        car_state <= dance ? 2'b00 : 2'b11;
                        if (!dance) car_mode <= 4'b0000;
                    end
                    default: cmd_err <= 1'b1;
                endcase
            end
        end
    end
endmodule

// File: doc/remote_cmd_decoder.md
Name: remote_cmd_decoder

Overview:
- Receives single-byte ASCII commands from the Bluetooth/UART remote link (8N1, LSB first).
- Decodes them into the car control bus consumed by the drive and lighting logic: car_mode, car_state, and the one-cycle toggle pulses shutdown, headlight and yellow_flash.
- Includes a failsafe watchdog that stops the car when the remote goes silent.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, UART bit rate. DIV = CLK_FREQ/BAUD (integer division), minimum 4.
- TIMEOUT_CYCLES, 50_000_000, idle cycles after the last drive command before forcing stop. A value of 0 disables the watchdog.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-low reset (0 = reset asserted).
- rx, input, 1, UART serial line, idle high, asynchronous to clk.
- car_mode, output, 4, [3:2] 10 = forward, 01 = back, 00 = none. [1:0] 10 = left, 01 = right, 00 = straight.
- car_state, output, 2, 00 = normal control, 11 = dance mode. Other codes are never driven.
- shutdown, output, 1, one-cycle pulse: toggle master lighting enable.
- headlight, output, 1, one-cycle pulse: toggle front blue lights.
- yellow_flash, output, 1, one-cycle pulse: toggle hazard flashers.
- frame_err, output, 1, one-cycle pulse on a bad stop bit.
- cmd_err, output, 1, one-cycle pulse on an unrecognised byte.

Behaviour:
- Reset (async, reset=0): all outputs 0, car_mode=0000, car_state=00, receiver in IDLE, counters cleared.
- Reset mid-byte: the partial byte is dropped. After release, the receiver waits for rx high before arming.
- rx input: two-flop synchroniser. All logic uses the synchronised copy rxs.
- Receiver FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. A bit counter runs 0..DIV-1.
  - IDLE: rxs=0 -> START, counter cleared.
  - START: at count DIV/2-1, if rxs=1 (glitch) -> IDLE, else -> DATA, counter cleared.
  - DATA: sample rxs at count DIV-1 (mid-bit) into the shift register, LSB first. After 8 bits -> STOP.
  - STOP: at count DIV-1, if rxs=1, byte valid (1-cycle internal strobe), -> IDLE. If rxs=0, frame_err pulse, byte discarded, -> WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then -> IDLE.
- Decode latency: outputs update (or pulses assert) on the clk edge after the valid strobe, i.e. 1 cycle after the stop-bit sample.
- Command map (ASCII):
  - 'F'(0x46): car_mode[3:2]=10.
  - 'B'(0x42): car_mode[3:2]=01.
  - 'L'(0x4C): car_mode[1:0]=10.
  - 'R'(0x52): car_mode[1:0]=01.
  - 'C'(0x43): car_mode[1:0]=00.
  - 'S'(0x53): car_mode=0000.
  - 'P'(0x50): shutdown pulse.
  - 'H'(0x48): headlight pulse.
  - 'Y'(0x59): yellow_flash pulse.
  - 'D'(0x44): car_state toggles 00<->11. Entering 11 forces car_mode=0000 in the same cycle.
  - Any other byte: cmd_err pulse, no other change.
- Lowercase bytes are not aliases; they raise cmd_err.
- Dance mode (car_state=11): F/B/L/R/C are ignored (no cmd_err) and car_mode stays 0000. S, P, H, Y and D remain active.
- Pulses are exactly one clk wide. At most one pulse per received byte, so pulses never overlap.
- Watchdog: 32-bit idle counter.
  - Cleared on every valid F/B/L/R/C/S byte and whenever car_mode=0000. Increments otherwise, saturating.
  - When the counter reaches TIMEOUT_CYCLES-1 with car_mode!=0000, car_mode <= 0000 on the next edge.
  - Non-drive bytes (P/H/Y/D/errors) do not clear the counter.
- Simultaneous events: if a valid drive command arrives in the same cycle the watchdog fires, the command wins. The new car_mode is applied and the counter is cleared.
- Back-to-back bytes: a start bit immediately after a valid stop bit is accepted, so no idle gap is required.

Test Plan:
- Use CLK_FREQ=16, BAUD=1 (DIV=16), TIMEOUT_CYCLES=1000 for all scenarios unless stated.
- Reset: hold reset=0 with rx toggling -> all outputs 0. Release, send 'F' -> car_mode=1000 one cycle after the stop-bit sample.
- Drive sequence: send 'F','L','R','C','B','S' back-to-back -> car_mode steps 1000, 1010, 1001, 1000, 0100, 0000. No cmd_err.
- Toggle pulses: send 'P','H','Y' -> shutdown, headlight and yellow_flash each high exactly 1 cycle, in order. car_mode unchanged.
- Dance mode: with car_mode=1010, send 'D' -> car_state=11, car_mode=0000. Send 'F' -> car_mode stays 0000, cmd_err stays 0. Send 'D' -> car_state=00.
- Errors: frame 0x46 with stop bit 0 -> frame_err 1 cycle, car_mode unchanged, no decode until rx returns high. Send 'x'(0x78) -> cmd_err 1 cycle. A start glitch of 4 cycles low -> no activity.
- Watchdog: send 'F', then idle -> car_mode=0000 exactly 1000 cycles after the decode. Repeat with 'L' sent at cycle 600 -> timeout re-based from the 'L' decode.
